// File: rtl/imem_responder.sv
// Instruction-fetch bus responder: decodes the fetch address, reads a synchronous
// word memory (1-cycle latency) and returns the word with a single-cycle ack.
module imem_responder #(
    parameter int          AW          = 12,
    parameter logic [31:0] BASE        = 32'h0000_0000,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] ERR_WORD    = 32'h0000_0000
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          bus_cyc,
    input  logic [31:0]   bus_adr,
    output logic          bus_ack,
    output logic [31:0]   bus_dat,
    output logic          bus_err,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [31:0]   mem_q
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DATA,
        S_WAIT,
        S_ERR,
        S_ACK
    } state_t;

    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t        state_reg, state_next;
    logic [3:0]    wait_cnt_reg, wait_cnt_next;
    logic [31:0]   data_reg, data_next;
    logic          err_reg, err_next;
    logic [AW-1:0] addr_next;
    logic          in_window;
    logic          unused_adr_bits;

    assign in_window       = (bus_adr[31:AW+2] == BASE[31:AW+2]);
    assign unused_adr_bits = ^bus_adr[1:0];

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        data_next     = data_reg;
        err_next      = err_reg;
        addr_next     = mem_addr;
        case (state_reg)
            S_IDLE: begin
                if (bus_cyc) begin
                    addr_next = bus_adr[AW+1:2];
                    err_next  = !in_window;
                    if (in_window) begin
                        state_next = S_READ;
                    end else begin
                        // Extra decode cycle keeps the error ack one cycle after sampling.
                        data_next  = ERR_WORD;
                        state_next = S_ERR;
                    end
                end
            end
            S_READ: begin
                state_next = bus_cyc ? S_DATA : S_IDLE;
            end
            S_DATA: begin
                if (!bus_cyc) begin
                    state_next = S_IDLE;
                end else begin
                    data_next = mem_q;
                    if (WAIT_STATES == 0) begin
                        state_next = S_ACK;
                    end else begin
                        wait_cnt_next = WAIT_LOAD;
                        state_next    = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!bus_cyc) begin
                    state_next = S_IDLE;
                end else if (wait_cnt_reg == 4'd0) begin
                    state_next = S_ACK;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 4'd1;
                end
            end
            S_ERR:   state_next = S_ACK;
            S_ACK:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so the ack lands in the S_ACK cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= S_IDLE;
            wait_cnt_reg <= 4'd0;
            data_reg     <= 32'd0;
            err_reg      <= 1'b0;
            bus_ack      <= 1'b0;
            bus_err      <= 1'b0;
            bus_dat      <= 32'd0;
            mem_rd       <= 1'b0;
            mem_addr     <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            data_reg     <= data_next;
            err_reg      <= err_next;
            bus_ack      <= (state_next == S_ACK);
            bus_err      <= (state_next == S_ACK) && err_next;
            mem_rd       <= (state_next == S_READ);
            mem_addr     <= addr_next;
            if (state_next == S_ACK) begin
                bus_dat <= data_next;
            end
        end
    end

endmodule
